// File: rtl/silu_pkg.sv
// Shared types and constants for the SiLU sequencer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package silu_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int FP16_W    = 16;
  localparam int DEF_LANES = 4;
  localparam logic [FP16_W-1:0] FP16_ONE = 16'h3C00;

  // All-zero vector at the default lane count, substituted for a timed-out result
  function automatic logic [FP16_W*DEF_LANES-1:0] zero_vec();
    return '0;
  endfunction

endpackage

// File: rtl/silu_out_fifo.sv
// Small synchronous FIFO holding completed SiLU result vectors.
// Latency: a push is visible at the head one cycle later; head is combinational from storage.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together keeps occupancy.
module silu_out_fifo
  import silu_pkg::*;
#(
  parameter int WIDTH = FP16_W * DEF_LANES,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot being written
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage, pointers and occupancy update
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/silu_seq_ctrl.sv
// Sequences one vector at a time through a SiLU unit: accept, pulse start, wait for Finished, queue result.
// Latency: accept at T, start pulse at T+1, Finished sampled from T+2, out_valid one cycle after capture.
// Backpressure: in_ready drops while the output FIFO is full; out_data holds while out_valid & !out_ready.
module silu_seq_ctrl
  import silu_pkg::*;
#(
  parameter int DATA_WIDTH = FP16_W,
  parameter int size       = DEF_LANES,
  parameter int TIMEOUT    = 64,
  parameter int OUT_DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [size*DATA_WIDTH-1:0] in_data,
  output logic [size*DATA_WIDTH-1:0] silu_x,
  output logic                       silu_start,
  input  logic                       silu_finished,
  input  logic [size*DATA_WIDTH-1:0] silu_product,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [size*DATA_WIDTH-1:0] out_data,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [15:0]                vec_count
);

  localparam int VW  = size * DATA_WIDTH;
  localparam int WCW = $clog2(TIMEOUT);
  localparam int CW  = $clog2(OUT_DEPTH + 1);

  state_t          state;
  state_t          state_nxt;
  logic [WCW-1:0]  wait_cnt;
  logic            done;
  logic            timed_out;
  logic            push;
  logic [VW-1:0]   push_dat;
  logic            accept;
  logic            pop;
  logic [VW-1:0]   fifo_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   occ;

  // Next state and per-state outputs; reset holds the unit cleared via silu_start
  always_comb begin
    state_nxt  = state;
    done       = 1'b0;
    timed_out  = 1'b0;
    push_dat   = '0;
    in_ready   = 1'b0;
    silu_start = reset;
    case (state)
      IDLE: begin
        in_ready = ~reset && (int'(occ) < OUT_DEPTH);
        if (in_valid && in_ready) state_nxt = START;
      end
      START: begin
        silu_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (silu_finished) begin
          done      = 1'b1;
          push_dat  = silu_product;
          state_nxt = IDLE;
        end else if (wait_cnt == WCW'(TIMEOUT - 1)) begin
          done      = 1'b1;
          timed_out = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;
  // in_ready gating already guarantees space; the full guard only protects storage
  assign push   = done & ~fifo_full;
  assign busy   = (state != IDLE);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // WAIT cycle counter, cleared while the start pulse is out
  always_ff @(posedge clk) begin
    if (reset)                                wait_cnt <= '0;
    else if (state == START)                  wait_cnt <= '0;
    else if (state == WAIT && !silu_finished) wait_cnt <= wait_cnt + 1'b1;
  end

  // Operand register: stable from one accept to the next
  always_ff @(posedge clk) begin
    if (reset)       silu_x <= '0;
    else if (accept) silu_x <= in_data;
  end

  // Sticky timeout flag and completed-vector counter
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err <= 1'b0;
      vec_count   <= '0;
    end else begin
      if (timed_out) timeout_err <= 1'b1;
      if (done)      vec_count   <= vec_count + 16'd1;
    end
  end

  assign out_valid = ~fifo_empty & ~reset;
  assign out_data  = reset ? '0 : fifo_head;
  assign pop       = out_valid & out_ready;

  silu_out_fifo #(
    .WIDTH (VW),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_dat),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occ)
  );

endmodule

// File: tb/tb_silu_seq_ctrl.sv
// Directed bench for silu_seq_ctrl with a bench-driven SiLU stub and an output scoreboard.
// Latency: inputs change on the falling edge; outputs are sampled away from the rising edge.
// Backpressure: out_ready is toggled per step to exercise FIFO stall, fill and drain.
module tb_silu_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [63:0] silu_x;
  logic        silu_start;
  logic        silu_finished;
  logic [63:0] silu_product;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;
  logic        timeout_err;
  logic [15:0] vec_count;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [15:0] exp_cnt;

  localparam logic [63:0] V_SINGLE = 64'h4000_3C00_9BDC_232F;
  localparam logic [63:0] V_BASE   = 64'h8543_0B43_ABFF_3C00;

  always #5 clk = ~clk;

  silu_seq_ctrl #(
    .DATA_WIDTH (16),
    .size       (4),
    .TIMEOUT    (64),
    .OUT_DEPTH  (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .silu_x        (silu_x),
    .silu_start    (silu_start),
    .silu_finished (silu_finished),
    .silu_product  (silu_product),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .vec_count     (vec_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer a vector until accepted, then check the one-cycle start pulse; returns in WAIT index 0
  task automatic send(input logic [63:0] v);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = v;
    for (int i = 0; i < 200 && !acc; i++) begin
      if (in_ready) acc = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("accepted", acc, 1);
    chk("start_high", silu_start, 1);
    chk("busy_start", busy, 1);
    chk("silu_x", silu_x, v);
    tick();
    chk("start_low", silu_start, 0);
  endtask

  // Stub unit: raise Finished with the result after lat WAIT cycles
  task automatic finish(input logic [63:0] v, input int lat);
    repeat (lat) tick();
    silu_finished = 1'b1;
    silu_product  = v;
    exp_q.push_back(v);
    exp_cnt++;
    tick();
    silu_finished = 1'b0;
    silu_product  = '0;
  endtask

  // Output monitor: every handshake must match the oldest expected vector
  always begin
    @(negedge clk);
    #3;
    if (out_valid && out_ready) begin
      chk("sb_has_entry", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("out_order", out_data, exp_q.pop_front());
    end
  end

  initial begin
    reset         = 1'b1;
    in_valid      = 1'b0;
    in_data       = '0;
    silu_finished = 1'b0;
    silu_product  = '0;
    out_ready     = 1'b0;
    exp_cnt       = '0;

    // Reset state
    tick();
    tick();
    chk("rst_start", silu_start, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_silu_x", silu_x, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_count", vec_count, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_start", silu_start, 0);
    chk("post_rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Single vector, stub latency 5
    send(V_SINGLE);
    finish(V_SINGLE, 4);
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, V_SINGLE);
    chk("single_count", vec_count, exp_cnt);
    chk("single_idle", busy, 0);
    out_ready = 1'b1;
    tick();
    chk("single_drained", out_valid, 0);

    // Stale Finished held through IDLE and START
    silu_finished = 1'b1;
    silu_product  = V_BASE ^ 64'hFFFF;
    send(V_BASE ^ 64'hFFFF);
    chk("stale_no_capture", out_valid, 0);
    chk("stale_count", vec_count, exp_cnt);
    exp_q.push_back(V_BASE ^ 64'hFFFF);
    exp_cnt++;
    out_ready = 1'b0;
    tick();
    silu_finished = 1'b0;
    chk("stale_capture_t2", out_valid, 1);
    chk("stale_data", out_data, V_BASE ^ 64'hFFFF);
    chk("stale_count2", vec_count, exp_cnt);
    out_ready = 1'b1;
    tick();

    // Backpressure: three vectors into a depth-2 FIFO
    out_ready = 1'b0;
    send(V_BASE);
    finish(V_BASE, 2);
    send(V_BASE + 64'd1);
    finish(V_BASE + 64'd1, 2);
    chk("bp_full_in_ready", in_ready, 0);
    in_valid = 1'b1;
    in_data  = V_BASE + 64'd2;
    repeat (3) begin
      tick();
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_not_busy", busy, 0);
      chk("bp_head_hold", out_data, V_BASE);
    end
    out_ready = 1'b1;
    send(V_BASE + 64'd2);
    finish(V_BASE + 64'd2, 2);
    repeat (3) tick();
    chk("bp_count", vec_count, exp_cnt);
    chk("bp_drained", out_valid, 0);

    // Timeout: stub never finishes
    out_ready = 1'b0;
    send(64'h1234_5678_9ABC_DEF0);
    repeat (63) tick();
    chk("to_not_yet_valid", out_valid, 0);
    chk("to_not_yet_err", timeout_err, 0);
    chk("to_still_busy", busy, 1);
    exp_q.push_back(64'h0);
    exp_cnt++;
    tick();
    chk("to_valid", out_valid, 1);
    chk("to_data_zero", out_data, 0);
    chk("to_err", timeout_err, 1);
    chk("to_count", vec_count, exp_cnt);
    out_ready = 1'b1;
    tick();
    send(64'h3C00_3C00_3C00_3C00);
    finish(64'h3C00_3C00_3C00_3C00, 3);
    tick();
    chk("to_recover_count", vec_count, exp_cnt);
    chk("to_err_sticky", timeout_err, 1);

    // Simultaneous push and pop with one entry resident
    out_ready = 1'b0;
    send(64'hAAAA_0001_BBBB_0002);
    finish(64'hAAAA_0001_BBBB_0002, 3);
    chk("pp_first_head", out_data, 64'hAAAA_0001_BBBB_0002);
    send(64'h5555_0003_6666_0004);
    repeat (2) tick();
    silu_finished = 1'b1;
    silu_product  = 64'h5555_0003_6666_0004;
    out_ready     = 1'b1;
    exp_q.push_back(64'h5555_0003_6666_0004);
    exp_cnt++;
    tick();
    silu_finished = 1'b0;
    out_ready     = 1'b0;
    chk("pp_valid", out_valid, 1);
    chk("pp_new_head", out_data, 64'h5555_0003_6666_0004);
    out_ready = 1'b1;
    tick();
    chk("pp_single_entry", out_valid, 0);

    // Reset while in WAIT with one entry in the FIFO
    out_ready = 1'b0;
    send(64'h0101_0202_0303_0404);
    finish(64'h0101_0202_0303_0404, 1);
    send(64'h0505_0606_0707_0808);
    chk("mr_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    chk("mr_out_valid", out_valid, 0);
    chk("mr_count", vec_count, 0);
    chk("mr_start", silu_start, 1);
    chk("mr_terr", timeout_err, 0);
    chk("mr_in_ready", in_ready, 0);
    exp_q.delete();
    exp_cnt = '0;
    reset   = 1'b0;
    #1;
    chk("mr_idle_in_ready", in_ready, 1);
    chk("mr_idle_busy", busy, 0);
    chk("mr_start_low", silu_start, 0);
    @(negedge clk);
    chk("mr_fifo_empty", out_valid, 0);

    // Normal operation after reset, then drain
    out_ready = 1'b1;
    send(64'hC000_BC00_4200_0000);
    finish(64'hC000_BC00_4200_0000, 2);
    repeat (4) tick();
    chk("final_count", vec_count, exp_cnt);
    chk("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
